// File: rtl/vc_requester.sv
`default_nettype none
// ============================================================================
// Module      : vc_requester
// Description : Requester side of the 8-way PCIe VC arbiter. Tracks pending
//               transactions per VC, drives the request vector, and runs a
//               fixed-length transfer burst for each legal grant.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_requester #(
    parameter int NUM_VC      = 8,
    parameter int DEPTH       = 4,
    parameter int XFER_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      enq,
    input  logic [$clog2(NUM_VC)-1:0] enq_vc,
    output logic                      enq_ready,
    input  logic [NUM_VC-1:0]         id,
    output logic [NUM_VC-1:0]         PCIe,
    output logic                      xfer_valid,
    output logic [$clog2(NUM_VC)-1:0] xfer_vc,
    output logic                      xfer_last,
    output logic                      grant_err,
    output logic                      enq_ovf
);

    localparam int c_VW = $clog2(NUM_VC);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_BW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [c_BW-1:0] c_LAST  = c_BW'(XFER_CYCLES - 1);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_XFER = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nx;
    logic [c_CW-1:0] r_cnt [NUM_VC];
    logic [c_CW-1:0] w_cnt_nx [NUM_VC];
    logic [c_BW-1:0] r_beat;
    logic [c_BW-1:0] w_beat_nx;
    logic [NUM_VC-1:0] r_pcie;
    logic [NUM_VC-1:0] w_pcie_nx;
    logic            r_xfer_valid;
    logic            w_xfer_valid_nx;
    logic [c_VW-1:0] r_xfer_vc;
    logic [c_VW-1:0] w_xfer_vc_nx;
    logic            r_xfer_last;
    logic            w_xfer_last_nx;
    logic            r_grant_err;
    logic            r_enq_ovf;
    logic            w_grant_bad;
    logic [c_VW-1:0] w_grant_idx;
    logic            w_last_beat;
    logic            w_inc;
    logic            w_ovf;

    assign enq_ready   = (r_cnt[enq_vc] < c_DEPTH);
    assign w_inc       = enq && enq_ready;
    assign w_ovf       = enq && !enq_ready;
    assign w_last_beat = (r_state == c_XFER) && (r_beat == c_LAST);

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (id[i]) begin
                w_grant_idx = c_VW'(i);
            end
        end
    end

    // Same-cycle enqueue and burst completion on one VC cancel out.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            w_cnt_nx[i] = r_cnt[i];
            if (w_inc && (enq_vc == c_VW'(i)) && !(w_last_beat && (r_xfer_vc == c_VW'(i)))) begin
                w_cnt_nx[i] = r_cnt[i] + c_CW'(1);
            end else if (w_last_beat && (r_xfer_vc == c_VW'(i)) && !(w_inc && (enq_vc == c_VW'(i)))) begin
                w_cnt_nx[i] = r_cnt[i] - c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_grant_bad = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (id != '0) begin
                    if ($onehot(id) && ((id & r_pcie) != '0)) begin
                        w_state_nx = c_XFER;
                    end else begin
                        w_grant_bad = 1'b1;
                    end
                end
            end
            c_XFER: begin
                if (w_last_beat) begin
                    w_state_nx = c_GAP;
                end
            end
            c_GAP:   w_state_nx = c_IDLE;
            default: w_state_nx = c_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        w_beat_nx    = '0;
        w_xfer_vc_nx = r_xfer_vc;
        if ((r_state == c_IDLE) && (w_state_nx == c_XFER)) begin
            w_xfer_vc_nx = w_grant_idx;
        end else if (r_state == c_XFER) begin
            w_beat_nx = c_BW'(r_beat + c_BW'(1));
        end
        w_xfer_valid_nx = (w_state_nx == c_XFER);
        w_xfer_last_nx  = w_xfer_valid_nx && (w_beat_nx == c_LAST);
        for (int i = 0; i < NUM_VC; i++) begin
            w_pcie_nx[i] = (w_state_nx != c_XFER) && (w_cnt_nx[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_cnt[i] <= '0;
            end
            r_beat       <= '0;
            r_pcie       <= '0;
            r_xfer_valid <= 1'b0;
            r_xfer_vc    <= '0;
            r_xfer_last  <= 1'b0;
            r_grant_err  <= 1'b0;
            r_enq_ovf    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_cnt[i] <= w_cnt_nx[i];
            end
            r_beat       <= w_beat_nx;
            r_pcie       <= w_pcie_nx;
            r_xfer_valid <= w_xfer_valid_nx;
            r_xfer_vc    <= w_xfer_vc_nx;
            r_xfer_last  <= w_xfer_last_nx;
            if (w_grant_bad) begin
                r_grant_err <= 1'b1;
            end
            if (w_ovf) begin
                r_enq_ovf <= 1'b1;
            end
        end
    end

    assign PCIe       = r_pcie;
    assign xfer_valid = r_xfer_valid;
    assign xfer_vc    = r_xfer_vc;
    assign xfer_last  = r_xfer_last;
    assign grant_err  = r_grant_err;
    assign enq_ovf    = r_enq_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vc_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_requester
// Description : Scenario bench for vc_requester with a burst-beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_requester;

    logic       clk = 1'b0;
    logic       clr;
    logic       enq;
    logic [2:0] enq_vc;
    logic       enq_ready;
    logic [7:0] id;
    logic [7:0] PCIe;
    logic       xfer_valid;
    logic [2:0] xfer_vc;
    logic       xfer_last;
    logic       grant_err;
    logic       enq_ovf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0] vc;
        logic       last;
    } beat_t;

    beat_t exp_q[$];

    vc_requester #(
        .NUM_VC(8),
        .DEPTH(4),
        .XFER_CYCLES(2)
    ) dut (
        .clk(clk),
        .clr(clr),
        .enq(enq),
        .enq_vc(enq_vc),
        .enq_ready(enq_ready),
        .id(id),
        .PCIe(PCIe),
        .xfer_valid(xfer_valid),
        .xfer_vc(xfer_vc),
        .xfer_last(xfer_last),
        .grant_err(grant_err),
        .enq_ovf(enq_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant a VC, queue its expected beats, then drain and check them.
    task automatic run_burst(input logic [2:0] vc, input logic [7:0] exp_gap_pcie);
        beat_t b;
        id = 8'(1) << vc;
        exp_q.push_back('{vc: vc, last: 1'b0});
        exp_q.push_back('{vc: vc, last: 1'b1});
        step();
        id = '0;
        n_cmp++;
        if (xfer_valid !== 1'b1) begin
            n_err++;
            $display("FAIL burst_latency vc%0d: xfer_valid=%b required 1", vc, xfer_valid);
        end
        for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
            if (xfer_valid === 1'b1) begin
                b = exp_q.pop_front();
                n_cmp++;
                if (xfer_vc !== b.vc || xfer_last !== b.last || PCIe !== 8'h00) begin
                    n_err++;
                    $display("FAIL burst_beat: vc=%0d last=%b PCIe=%b required vc=%0d last=%b PCIe=00000000",
                             xfer_vc, xfer_last, PCIe, b.vc, b.last);
                end
            end
            if (exp_q.size() > 0) step();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL burst_timeout: %0d beats outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        step();
        n_cmp++;
        if (xfer_valid !== 1'b0 || PCIe !== exp_gap_pcie) begin
            n_err++;
            $display("FAIL burst_gap: xfer_valid=%b PCIe=%b required 0 %b", xfer_valid, PCIe, exp_gap_pcie);
        end
        step();
    endtask

    task automatic test_reset();
        clr = 1'b1; enq = 1'b1; enq_vc = 3'd5; id = '0;
        step();
        step();
        clr = 1'b0; enq = 1'b0;
        n_cmp++;
        if (PCIe !== 8'h00 || xfer_valid !== 1'b0 || xfer_last !== 1'b0 || xfer_vc !== 3'd0) begin
            n_err++;
            $display("FAIL reset_outputs: PCIe=%b valid=%b last=%b vc=%0d required 0", PCIe, xfer_valid, xfer_last, xfer_vc);
        end
        n_cmp++;
        if (grant_err !== 1'b0 || enq_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: grant_err=%b enq_ovf=%b required 0 0", grant_err, enq_ovf);
        end
        step();
        n_cmp++;
        if (PCIe !== 8'h00) begin
            n_err++;
            $display("FAIL reset_enq_dropped: PCIe=%b required 00000000", PCIe);
        end
    endtask

    task automatic test_enqueue();
        enq = 1'b1; enq_vc = 3'd1;
        step();
        n_cmp++;
        if (PCIe !== 8'b0000_0010) begin
            n_err++;
            $display("FAIL enq_vc1: PCIe=%b required 00000010", PCIe);
        end
        enq_vc = 3'd2;
        step();
        enq = 1'b0;
        n_cmp++;
        if (PCIe !== 8'b0000_0110) begin
            n_err++;
            $display("FAIL enq_vc2: PCIe=%b required 00000110", PCIe);
        end
    endtask

    task automatic test_burst();
        run_burst(3'd1, 8'b0000_0100);
    endtask

    task automatic test_bad_grant();
        id = 8'b0000_1000;
        step();
        id = '0;
        n_cmp++;
        if (grant_err !== 1'b1 || xfer_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bad_grant_unrequested: grant_err=%b valid=%b required 1 0", grant_err, xfer_valid);
        end
        id = 8'b0000_0110;
        step();
        id = '0;
        n_cmp++;
        if (grant_err !== 1'b1 || xfer_valid !== 1'b0 || PCIe !== 8'b0000_0100) begin
            n_err++;
            $display("FAIL bad_grant_multihot: grant_err=%b valid=%b PCIe=%b required 1 0 00000100",
                     grant_err, xfer_valid, PCIe);
        end
        step();
        n_cmp++;
        if (xfer_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bad_grant_no_burst: xfer_valid=%b required 0", xfer_valid);
        end
    endtask

    task automatic test_overflow();
        logic exp_ready;
        enq_vc = 3'd3;
        for (int i = 0; i < 5; i++) begin
            enq = 1'b1;
            exp_ready = (i < 4);
            #1;
            n_cmp++;
            if (enq_ready !== exp_ready) begin
                n_err++;
                $display("FAIL ovf_ready[%0d]: enq_ready=%b required %b", i, enq_ready, exp_ready);
            end
            step();
        end
        enq = 1'b0;
        n_cmp++;
        if (enq_ovf !== 1'b1 || PCIe !== 8'b0000_1100 || enq_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_flag: enq_ovf=%b PCIe=%b ready=%b required 1 00001100 0", enq_ovf, PCIe, enq_ready);
        end
        // One burst on vc3 must leave exactly three pending, so ready returns.
        run_burst(3'd3, 8'b0000_1100);
        #1;
        n_cmp++;
        if (enq_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_count_held: enq_ready=%b required 1", enq_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        id = 8'b0000_0100;
        step();
        id = '0;
        n_cmp++;
        if (xfer_valid !== 1'b1 || xfer_vc !== 3'd2) begin
            n_err++;
            $display("FAIL midrst_first_beat: valid=%b vc=%0d required 1 2", xfer_valid, xfer_vc);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++;
        if (xfer_valid !== 1'b0 || PCIe !== 8'h00 || enq_ovf !== 1'b0 || grant_err !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_abort: valid=%b PCIe=%b ovf=%b gerr=%b required 0 00000000 0 0",
                     xfer_valid, PCIe, enq_ovf, grant_err);
        end
        enq = 1'b1; enq_vc = 3'd2;
        step();
        enq = 1'b0;
        n_cmp++;
        if (PCIe !== 8'b0000_0100 || xfer_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_reenq: PCIe=%b valid=%b required 00000100 0", PCIe, xfer_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; enq = 1'b0; enq_vc = '0; id = '0;
        test_reset();
        test_enqueue();
        test_burst();
        test_bad_grant();
        test_overflow();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
